cache_control: RTL and testbench

Controller and line-merge logic for the direct-mapped, write-back L1 cache. It sits between the CPU memory port and the physical-memory port. It drives the index, write strobes and write data of the external data array (WIDTH bits × SETS) and tag array (TAG_W bits × SETS), and reads their combinational outputs. It also owns the per-set valid and dirty bits and the hit/miss/writeback/fill state machine.

---
 rtl/cache_control.sv | 164 ++++++++++++++++
 tb/tb_cache_control.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// cache_control: direct-mapped write-back L1 controller; owns valid/dirty bits, the hit/miss FSM and the write-hit line merge.
// Latency: a hit completes in the cycle it is first seen in IDLE; a miss costs [writeback cycles] + fill cycles + 1.
// Backpressure: the CPU request is held until mem_resp; pmem_read/pmem_write are held until pmem_resp.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_read/mem_write/mem_*          CPU request side; mem_rdata/mem_resp completion
//   pmem_read/pmem_write/pmem_*       physical-memory line fill / writeback
//   array_index, data_*, tag_*        external data and tag arrays (combinational read outputs)
//   miss_count                        live miss counter when CACHE_MISS_CTR_EN is defined, else tied to 0
//
// Optional feature macro: CACHE_MISS_CTR_EN

module cache_control #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned SETS  = 8,
   parameter int unsigned TAG_W = 9,
   localparam int unsigned IDX_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [1:0]       mem_byte_enable,
   input  logic [15:0]      mem_address,
   input  logic [15:0]      mem_wdata,
   output logic [15:0]      mem_rdata,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic [15:0]      pmem_address,
   input  logic [WIDTH-1:0] pmem_rdata,
   input  logic             pmem_resp,
   output logic [IDX_W-1:0] array_index,
   output logic             data_write,
   output logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] data_out,
   output logic             tag_write,
   input  logic [TAG_W-1:0] tag_out,
   output logic [15:0]      miss_count
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FILL      = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SETS-1:0]   valid_q, valid_d;
   logic [SETS-1:0]   dirty_q, dirty_d;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  req_tag;
   logic [2:0]        word;
   logic              req;
   logic              hit;
   logic [WIDTH-1:0]  merged;
   logic              unused_addr_lsb;

   assign idx             = mem_address[4 +: IDX_W];
   assign req_tag         = mem_address[15 -: TAG_W];
   assign word            = mem_address[3:1];
   assign array_index     = idx;
   assign req             = mem_read | mem_write;
   assign hit             = valid_q[idx] && (tag_out == req_tag);
   assign unused_addr_lsb = mem_address[0];

   // Resident line with the enabled byte lanes of the addressed word replaced.
   always_comb begin
      merged = data_out;
      if (mem_byte_enable[0]) merged[{word, 4'b0000} +: 8] = mem_wdata[7:0];
      if (mem_byte_enable[1]) merged[{word, 4'b1000} +: 8] = mem_wdata[15:8];
   end

   // All outputs are decoded from the current state; reset forces them quiet
   // so an abandoned writeback/fill is dropped immediately.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      data_write   = 1'b0;
      data_in      = '0;
      tag_write    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  if (hit) begin
                     mem_resp = 1'b1;
                     // A simultaneous read+write is serviced as a write.
                     if (mem_write) begin
                        data_write   = 1'b1;
                        data_in      = merged;
                        dirty_d[idx] = 1'b1;
                     end else begin
                        mem_rdata = data_out[{word, 4'b0000} +: 16];
                     end
                  end else if (valid_q[idx] && dirty_q[idx]) begin
                     state_d = S_WRITEBACK;
                  end else begin
                     state_d = S_FILL;
                  end
               end
            end
            S_WRITEBACK: begin
               pmem_write   = 1'b1;
               pmem_address = {tag_out, idx, 4'b0000};
               if (pmem_resp) state_d = S_FILL;
            end
            S_FILL: begin
               pmem_read    = 1'b1;
               pmem_address = {mem_address[15:4], 4'b0000};
               if (pmem_resp) begin
                  data_write   = 1'b1;
                  data_in      = pmem_rdata;
                  tag_write    = 1'b1;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b0;
                  state_d      = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

`ifdef CACHE_MISS_CTR_EN
   logic [15:0] miss_q, miss_d;

   // Counts once per miss, on the IDLE cycle that detects it; wraps naturally.
   always_comb begin
      miss_d = miss_q;
      if (state_q == S_IDLE && req && !hit) miss_d = miss_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) miss_q <= '0;
      else     miss_q <= miss_d;
   end

   assign miss_count = miss_q;
`else
   assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: randomized scoreboard bench for cache_control with array and physical-memory models.
// Latency: expected responses are queued at issue time and matched when mem_resp / pmem_resp appear.
// Backpressure: requests are held until mem_resp; pmem responses arrive after a random 0-3 cycle delay.

module tb_cache_control;

   localparam int WIDTH = 128;
   localparam int SETS  = 8;
   localparam int TAG_W = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_read, mem_write;
   logic [1:0]        mem_byte_enable;
   logic [15:0]       mem_address, mem_wdata, mem_rdata;
   logic              mem_resp;
   logic              pmem_read, pmem_write;
   logic [15:0]       pmem_address;
   logic [WIDTH-1:0]  pmem_rdata;
   logic              pmem_resp;
   logic [2:0]        array_index;
   logic              data_write;
   logic [WIDTH-1:0]  data_in, data_out;
   logic              tag_write;
   logic [TAG_W-1:0]  tag_out;
   logic [15:0]       miss_count;

   always #5 clk = ~clk;

   cache_control #(.WIDTH(WIDTH), .SETS(SETS), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .array_index(array_index), .data_write(data_write), .data_in(data_in), .data_out(data_out),
      .tag_write(tag_write), .tag_out(tag_out), .miss_count(miss_count)
   );

   // ---------------- external data / tag arrays ----------------
   logic [WIDTH-1:0] data_arr [SETS];
   logic [TAG_W-1:0] tag_arr  [SETS];
   assign data_out = data_arr[array_index];
   assign tag_out  = tag_arr[array_index];
   always @(posedge clk) begin
      if (data_write) data_arr[array_index] <= data_in;
      if (tag_write)  tag_arr[array_index]  <= mem_address[15:7];
   end

   // ---------------- physical memory and reference model ----------------
   logic [WIDTH-1:0] pmem_lines [4096];   // indexed by address[15:4]
   logic [15:0]      shadow     [32768];  // CPU-visible memory, indexed by address[15:1]
   bit               m_valid [SETS];
   bit               m_dirty [SETS];
   logic [TAG_W-1:0] m_tag   [SETS];
   logic [15:0]      m_miss;

   typedef struct {
      bit          is_wr;
      logic [15:0] rdata;
      bit          miss;
      bit          wb;
      logic [15:0] wb_addr;
      logic [127:0] wb_data;
      logic [15:0] fill_addr;
      logic [15:0] cnt;
      int          t_issue;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   wb_c = 0, fill_c = 0;
   bit   hold_fill = 1'b0;
   bit   stray_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [127:0] act, logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] init_word(int i);
      return 16'((i * 40503) ^ 16'h5A5A);
   endfunction

   function automatic logic [127:0] shadow_line(logic [15:0] la);
      logic [127:0] l;
      for (int w = 0; w < 8; w++) l[16*w +: 16] = shadow[{la[15:4], 3'(w)}];
      return l;
   endfunction

   // Cache behaviour from the CPU's point of view: which lines are resident,
   // which are modified, and what every byte of memory should read as.
   task automatic model_req(input logic [15:0] a, input bit wr, input logic [1:0] be,
                            input logic [15:0] wd, output exp_t e);
      int         ix;
      logic [8:0] tg;
      logic [14:0] wa;
      bit         h;
      ix = int'(a[6:4]);
      tg = a[15:7];
      wa = a[15:1];
      h  = m_valid[ix] && (m_tag[ix] == tg);
      e.miss      = !h;
      e.wb        = !h && m_valid[ix] && m_dirty[ix];
      e.wb_addr   = {m_tag[ix], a[6:4], 4'h0};
      e.wb_data   = e.wb ? shadow_line(e.wb_addr) : '0;
      e.fill_addr = {a[15:4], 4'h0};
      if (!h) begin
         m_miss      = m_miss + 16'd1;
         m_valid[ix] = 1'b1;
         m_tag[ix]   = tg;
         m_dirty[ix] = 1'b0;
      end
      if (wr) begin
         if (be[0]) shadow[wa][7:0]  = wd[7:0];
         if (be[1]) shadow[wa][15:8] = wd[15:8];
         m_dirty[ix] = 1'b1;
      end
      e.is_wr = wr;
      e.rdata = shadow[wa];
`ifdef CACHE_MISS_CTR_EN
      e.cnt = m_miss;
`else
      e.cnt = 16'h0000;
`endif
      e.t_issue = 0;
   endtask

   // A reset discards resident lines, so modified data reverts to memory.
   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         if (m_valid[s] && m_dirty[s]) begin
            logic [11:0] la;
            la = {m_tag[s], 3'(s)};
            for (int w = 0; w < 8; w++) shadow[{la, 3'(w)}] = pmem_lines[la][16*w +: 16];
         end
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
      end
      m_miss = 16'h0000;
   endtask

   // ---------------- physical-memory responder ----------------
   int wait_cnt = 0;
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (pmem_resp || rst) begin
            pmem_resp = 1'b0;
         end else if (pmem_write) begin
            if (wait_cnt == 0) begin
               pmem_resp = 1'b1;
               pmem_lines[pmem_address[15:4]] = data_out;
               wait_cnt = $urandom_range(0, 3);
            end else wait_cnt--;
         end else if (pmem_read && !hold_fill) begin
            if (wait_cnt == 0) begin
               pmem_resp  = 1'b1;
               pmem_rdata = pmem_lines[pmem_address[15:4]];
               wait_cnt = $urandom_range(0, 3);
            end else wait_cnt--;
         end else if (!pmem_read && stray_en && $urandom_range(0, 7) == 0) begin
            pmem_resp = 1'b1;   // stray pulse while idle must be ignored
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   exp_t me;
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_resp || pmem_read || pmem_write || data_write || tag_write)
            check("exclusive_strobes",
                  (mem_resp && (pmem_read || pmem_write)) || (pmem_read && pmem_write) ||
                  (data_write && pmem_write) || (tag_write && !(pmem_read && data_write)), 0);
         if (pmem_write) wb_c++;
         if (pmem_read)  fill_c++;
         if (pmem_resp && (pmem_read || pmem_write)) begin
            if (exp_q.size() == 0) check("pmem_unexpected", 1, 0);
            else if (pmem_write) begin
               check("wb_addr", pmem_address, exp_q[0].wb_addr);
               check("wb_data", data_out, exp_q[0].wb_data);
            end else begin
               check("fill_addr", pmem_address, exp_q[0].fill_addr);
            end
         end
         if (mem_resp) begin
            if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
            else begin
               me = exp_q.pop_front();
               check("resp_missed", fill_c != 0, me.miss);
               check("resp_wrote_back", wb_c != 0, me.wb);
               check("data_write_on_resp", data_write, me.is_wr);
               if (!me.is_wr) check("rdata", mem_rdata, me.rdata);
               check("miss_count", miss_count, me.cnt);
               check("latency", 128'(cyc - me.t_issue), 128'(wb_c + fill_c + (me.miss ? 1 : 0)));
            end
            wb_c   = 0;
            fill_c = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic finish_now(string why);
      checks++;
      errors++;
      $display("FAIL %s: no DUT response within bound", why);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic issue(input logic [15:0] a, input bit rd, input bit wr,
                        input logic [1:0] be, input logic [15:0] wd);
      exp_t e;
      bit   done;
      model_req(a, wr, be, wd, e);
      @(posedge clk); #2;
      e.t_issue = cyc;
      exp_q.push_back(e);
      mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (mem_resp) done = 1'b1;
      end
      if (!done) finish_now("mem_resp_timeout");
      @(posedge clk); #2;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic reset_mid_fill(input logic [15:0] a);
      exp_t e;
      bit   seen;
      hold_fill = 1'b1;
      model_req(a, 1'b0, 2'b00, 16'h0, e);
      @(posedge clk); #2;
      e.t_issue = cyc;
      exp_q.push_back(e);
      mem_address = a; mem_read = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (pmem_read) seen = 1'b1;
      end
      if (!seen) finish_now("fill_start_timeout");
      repeat (2) @(negedge clk);
      check("fill_held", pmem_read, 1);
      @(posedge clk); #2;
      rst = 1'b1; mem_read = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      check("rst_fill_pmem_read", pmem_read, 0);
      check("rst_fill_pmem_write", pmem_write, 0);
      check("rst_fill_mem_resp", mem_resp, 0);
      check("rst_fill_miss_count", miss_count, 0);
      exp_q.delete();
      wb_c = 0; fill_c = 0;
      hold_fill = 1'b0;
      model_reset();
      issue(a, 1'b1, 1'b0, 2'b00, 16'h0);   // must miss again
   endtask

   initial begin
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
      mem_address = '0; mem_wdata = '0;
      for (int s = 0; s < SETS; s++) begin
         data_arr[s] = {$urandom, $urandom, $urandom, $urandom};
         tag_arr[s]  = TAG_W'($urandom);
         m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_tag[s] = '0;
      end
      for (int i = 0; i < 32768; i++) shadow[i] = init_word(i);
      for (int la = 0; la < 4096; la++)
         for (int w = 0; w < 8; w++) pmem_lines[la][16*w +: 16] = init_word(la * 8 + w);
      shadow[15'h091A]          = 16'hABCD;   // word 2 of line 0x1230
      pmem_lines[12'h123][47:32] = 16'hABCD;
      m_miss = 16'h0000;

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset_mem_resp", mem_resp, 0);
      check("reset_pmem_read", pmem_read, 0);
      check("reset_pmem_write", pmem_write, 0);
      check("reset_data_write", data_write, 0);
      check("reset_tag_write", tag_write, 0);
      check("reset_mem_rdata", mem_rdata, 0);
      check("reset_pmem_address", pmem_address, 0);
      check("reset_miss_count", miss_count, 0);

      issue(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0000);   // cold read
      issue(16'h1236, 1'b0, 1'b1, 2'b10, 16'h55AA);   // byte-lane write hit
      issue(16'h1236, 1'b1, 1'b0, 2'b00, 16'h0000);
      issue(16'h2234, 1'b1, 1'b0, 2'b00, 16'h0000);   // dirty eviction
      issue(16'h0030, 1'b1, 1'b0, 2'b00, 16'h0000);   // clean conflict
      issue(16'h4030, 1'b1, 1'b0, 2'b00, 16'h0000);
      issue(16'h4030, 1'b0, 1'b1, 2'b00, 16'hFFFF);   // no lanes enabled
      issue(16'h4030, 1'b1, 1'b1, 2'b11, 16'h1357);   // read+write -> write
      issue(16'h4030, 1'b1, 1'b0, 2'b00, 16'h0000);
      reset_mid_fill(16'h5550);

      stray_en = 1'b1;
      for (int k = 0; k < 300; k++) begin
         logic [15:0] a;
         bit rd, wr;
         a  = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0};
         wr = ($urandom_range(0, 2) == 0);
         rd = !wr || ($urandom_range(0, 3) == 0);
         issue(a, rd, wr, 2'($urandom), 16'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      stray_en = 1'b0;

      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      finish_now("global_watchdog");
   end

endmodule
